// File: rtl/alarm_unit.sv
// Alarm stage behind the time-of-day counter: holds a BCD alarm time and
// runs the arm / ring / snooze sequence, all on the 1 Hz tick.
module alarm_unit #(
    parameter logic [1:0]  MODE_SEL    = 2'b01,
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clk1sec,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic       hrbtn,
    input  logic       minbtn,
    input  logic       armbtn,
    input  logic       snzbtn,
    input  logic [3:0] tenhr_in,
    input  logic [3:0] onehr_in,
    input  logic [3:0] tenmin_in,
    input  logic [3:0] onemin_in,
    output logic [3:0] al_tenhr,
    output logic [3:0] al_onehr,
    output logic [3:0] al_tenmin,
    output logic [3:0] al_onemin,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing
);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

    state_t     state, state_n;
    logic [7:0] ring_cnt, ring_cnt_n;
    logic [9:0] snz_cnt, snz_cnt_n;
    logic [1:0] snz_num, snz_num_n;
    logic       hr_q, min_q, arm_q, snz_q, match_d;
    logic       hr_rise, min_rise, arm_rise, snz_rise, match, match_rise, edit;
    logic [3:0] tenhr_n, onehr_n, tenmin_n, onemin_n;

    assign hr_rise    = hrbtn & ~hr_q;
    assign min_rise   = minbtn & ~min_q;
    assign arm_rise   = armbtn & ~arm_q;
    assign snz_rise   = snzbtn & ~snz_q;
    assign edit       = (sel == MODE_SEL);
    assign match      = (tenhr_in == al_tenhr) && (onehr_in == al_onehr) &&
                        (tenmin_in == al_tenmin) && (onemin_in == al_onemin);
    assign match_rise = match & ~match_d;

    assign armed    = (state != IDLE);
    assign ringing  = (state == RINGING);
    assign snoozing = (state == SNOOZE);

    // Hours roll 12 -> 01; minutes roll 59 -> 00 without touching the hour.
    always_comb begin
        tenhr_n  = al_tenhr;
        onehr_n  = al_onehr;
        tenmin_n = al_tenmin;
        onemin_n = al_onemin;
        if (edit && hr_rise) begin
            if (al_tenhr == 4'd1 && al_onehr == 4'd2) begin
                tenhr_n = 4'd0;
                onehr_n = 4'd1;
            end else if (al_onehr == 4'd9) begin
                tenhr_n = 4'd1;
                onehr_n = 4'd0;
            end else begin
                onehr_n = al_onehr + 4'd1;
            end
        end
        if (edit && min_rise) begin
            if (al_onemin == 4'd9) begin
                onemin_n = 4'd0;
                tenmin_n = (al_tenmin == 4'd5) ? 4'd0 : al_tenmin + 4'd1;
            end else begin
                onemin_n = al_onemin + 4'd1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        snz_num_n  = snz_num;
        case (state)
            IDLE: begin
                if (arm_rise) state_n = ARMED;
            end
            ARMED: begin
                if (arm_rise) begin
                    state_n = IDLE;
                end else if (match_rise) begin
                    state_n    = RINGING;
                    ring_cnt_n = '0;
                    snz_num_n  = '0;
                end
            end
            RINGING: begin
                ring_cnt_n = ring_cnt + 8'd1;
                if (arm_rise) begin
                    state_n = ARMED;
                end else if (snz_rise && snz_num < SNZ_MAX) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = '0;
                    snz_num_n = snz_num + 2'd1;
                end else if (ring_cnt == RING_LAST) begin
                    state_n = ARMED;
                end
            end
            SNOOZE: begin
                snz_cnt_n = snz_cnt + 10'd1;
                if (arm_rise) begin
                    state_n = ARMED;
                end else if (snz_cnt == SNZ_LAST) begin
                    state_n    = RINGING;
                    ring_cnt_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk1sec or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            snz_cnt   <= '0;
            snz_num   <= '0;
            hr_q      <= 1'b0;
            min_q     <= 1'b0;
            arm_q     <= 1'b0;
            snz_q     <= 1'b0;
            match_d   <= 1'b0;
            al_tenhr  <= 4'd0;
            al_onehr  <= 4'd6;
            al_tenmin <= 4'd0;
            al_onemin <= 4'd0;
        end else begin
            state     <= state_n;
            ring_cnt  <= ring_cnt_n;
            snz_cnt   <= snz_cnt_n;
            snz_num   <= snz_num_n;
            hr_q      <= hrbtn;
            min_q     <= minbtn;
            arm_q     <= armbtn;
            snz_q     <= snzbtn;
            match_d   <= match;
            al_tenhr  <= tenhr_n;
            al_onehr  <= onehr_n;
            al_tenmin <= tenmin_n;
            al_onemin <= onemin_n;
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: constant vector table, directed multi-cycle
// sequences and a random run, all checked against a behavioural model.
module tb_alarm_unit;

    localparam logic [1:0]  MODE_SEL    = 2'b01;
    localparam int unsigned RING_SECS   = 60;
    localparam int unsigned SNOOZE_SECS = 300;
    localparam int unsigned MAX_SNOOZE  = 3;

    logic       clk1sec = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b00;
    logic       hrbtn = 1'b0, minbtn = 1'b0, armbtn = 1'b0, snzbtn = 1'b0;
    logic [3:0] tenhr_in, onehr_in, tenmin_in, onemin_in;
    logic [3:0] al_tenhr, al_onehr, al_tenmin, al_onemin;
    logic       armed, ringing, snoozing;
    int         cur_h = 3, cur_m = 0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk1sec = ~clk1sec;

    always_comb begin
        tenhr_in  = 4'(cur_h / 10);
        onehr_in  = 4'(cur_h % 10);
        tenmin_in = 4'(cur_m / 10);
        onemin_in = 4'(cur_m % 10);
    end

    alarm_unit #(
        .MODE_SEL(MODE_SEL), .RING_SECS(RING_SECS),
        .SNOOZE_SECS(SNOOZE_SECS), .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk1sec(clk1sec), .rst(rst), .sel(sel),
        .hrbtn(hrbtn), .minbtn(minbtn), .armbtn(armbtn), .snzbtn(snzbtn),
        .tenhr_in(tenhr_in), .onehr_in(onehr_in),
        .tenmin_in(tenmin_in), .onemin_in(onemin_in),
        .al_tenhr(al_tenhr), .al_onehr(al_onehr),
        .al_tenmin(al_tenmin), .al_onemin(al_onemin),
        .armed(armed), .ringing(ringing), .snoozing(snoozing)
    );

    logic [15:0] dut_al;
    logic [15:0] dut_st;
    assign dut_al = {al_tenhr, al_onehr, al_tenmin, al_onemin};
    assign dut_st = {13'd0, armed, ringing, snoozing};

    // Model: alarm as integer hour/minute, mode as flags, countdowns of
    // edges remaining rather than up-counters.
    int m_alh, m_alm;
    bit m_armed, m_ring, m_snz;
    int ring_left, snz_left, snz_used;
    bit p_hr, p_mi, p_arm, p_snz, p_match;

    task automatic model_reset();
        m_alh = 6; m_alm = 0;
        m_armed = 0; m_ring = 0; m_snz = 0;
        ring_left = 0; snz_left = 0; snz_used = 0;
        p_hr = 0; p_mi = 0; p_arm = 0; p_snz = 0; p_match = 0;
    endtask

    task automatic model_step();
        bit hr_e, mi_e, arm_e, snz_e, hit, rise;
        hr_e  = hrbtn && !p_hr;
        mi_e  = minbtn && !p_mi;
        arm_e = armbtn && !p_arm;
        snz_e = snzbtn && !p_snz;
        p_hr = hrbtn; p_mi = minbtn; p_arm = armbtn; p_snz = snzbtn;
        hit = (cur_h == m_alh) && (cur_m == m_alm);
        rise = hit && !p_match;
        p_match = hit;
        if (sel == MODE_SEL) begin
            if (hr_e) m_alh = m_alh % 12 + 1;
            if (mi_e) m_alm = (m_alm + 1) % 60;
        end
        if (!m_armed) begin
            if (arm_e) m_armed = 1;
        end else if (m_ring) begin
            if (arm_e) m_ring = 0;
            else if (snz_e && snz_used < int'(MAX_SNOOZE)) begin
                m_ring = 0; m_snz = 1; snz_left = SNOOZE_SECS; snz_used++;
            end else begin
                ring_left--;
                if (ring_left == 0) m_ring = 0;
            end
        end else if (m_snz) begin
            if (arm_e) m_snz = 0;
            else begin
                snz_left--;
                if (snz_left == 0) begin
                    m_snz = 0; m_ring = 1; ring_left = RING_SECS;
                end
            end
        end else begin
            if (arm_e) m_armed = 0;
            else if (rise) begin
                m_ring = 1; ring_left = RING_SECS; snz_used = 0;
            end
        end
    endtask

    function automatic logic [15:0] model_al();
        return {4'(m_alh / 10), 4'(m_alh % 10), 4'(m_alm / 10), 4'(m_alm % 10)};
    endfunction

    function automatic logic [15:0] model_st();
        return {13'd0, m_armed, m_ring, m_snz};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk1sec);
        #1;
        chk("model_al", dut_al, model_al());
        chk("model_st", dut_st, model_st());
    endtask

    task automatic press(input int which);
        case (which)
            0: hrbtn = 1'b1;
            1: minbtn = 1'b1;
            2: armbtn = 1'b1;
            default: snzbtn = 1'b1;
        endcase
        tick();
        hrbtn = 1'b0; minbtn = 1'b0; armbtn = 1'b0; snzbtn = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        hr, mi, arm, snz;
        logic [15:0] exp_al;
        logic [2:0]  exp_st;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic [1:0] s, input logic h, input logic m,
                       input logic a, input logic z, input logic [15:0] al,
                       input logic [2:0] st);
        vec_t v;
        v.sel = s; v.hr = h; v.mi = m; v.arm = a; v.snz = z;
        v.exp_al = al; v.exp_st = st;
        vecs.push_back(v);
    endtask

    initial begin
        model_reset();
        // Hour stepping 06 -> 01, hold-no-repeat, sel gating, dual edit.
        add(2'b01, 1, 0, 0, 0, 16'h0700, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0700, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h0800, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0800, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h0900, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0900, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h1000, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h1000, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h1100, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h1100, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h1200, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h1200, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h0100, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0100, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h0200, 3'b000);
        add(2'b01, 1, 0, 0, 0, 16'h0200, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0200, 3'b000);
        add(2'b00, 1, 0, 0, 0, 16'h0200, 3'b000);
        add(2'b00, 0, 0, 0, 0, 16'h0200, 3'b000);
        add(2'b01, 1, 1, 0, 0, 16'h0301, 3'b000);
        add(2'b01, 0, 0, 0, 0, 16'h0301, 3'b000);

        repeat (2) @(posedge clk1sec);
        @(negedge clk1sec);
        chk("reset_al", dut_al, 16'h0600);
        chk("reset_st", dut_st, 16'h0000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sel = vecs[i].sel; hrbtn = vecs[i].hr; minbtn = vecs[i].mi;
            armbtn = vecs[i].arm; snzbtn = vecs[i].snz;
            tick();
            chk("vec_al", dut_al, vecs[i].exp_al);
            chk("vec_st", dut_st, {13'd0, vecs[i].exp_st});
        end
        hrbtn = 0; minbtn = 0;

        // Minute wrap 59 -> 00 leaves the hour alone.
        for (int i = 0; i < 58; i++) press(1);
        chk("min_59", dut_al, 16'h0359);
        press(1);
        chk("min_wrap", dut_al, 16'h0300);
        sel = 2'b00;
        press(0);
        chk("sel_gate", dut_al, 16'h0300);
        sel = MODE_SEL;
        for (int i = 0; i < 3; i++) press(0);
        chk("back_to_0600", dut_al, 16'h0600);
        sel = 2'b00;

        // Arm, ring on first matching edge, auto-dismiss, no re-ring.
        cur_h = 5; cur_m = 59;
        press(2);
        chk("armed", dut_st, 16'h0004);
        cur_h = 6; cur_m = 0;
        tick();
        chk("ring_latency", dut_st, 16'h0006);
        repeat (RING_SECS - 1) tick();
        chk("ring_last_sec", dut_st, 16'h0006);
        tick();
        chk("auto_dismiss", dut_st, 16'h0004);
        repeat (10) tick();
        chk("no_retrigger", dut_st, 16'h0004);

        // Three snoozes, fourth ignored.
        cur_m = 1; tick();
        cur_m = 0; tick();
        chk("rering", dut_st, 16'h0006);
        for (int k = 0; k < 3; k++) begin
            snzbtn = 1'b1; tick();
            chk("snooze_enter", dut_st, 16'h0005);
            snzbtn = 1'b0;
            repeat (SNOOZE_SECS - 1) tick();
            chk("snooze_hold", dut_st, 16'h0005);
            tick();
            chk("snooze_expire", dut_st, 16'h0006);
        end
        snzbtn = 1'b1; tick();
        chk("snooze_limit", dut_st, 16'h0006);
        snzbtn = 1'b0; tick();
        armbtn = 1'b1; snzbtn = 1'b1; tick();
        chk("arm_over_snz", dut_st, 16'h0004);
        armbtn = 1'b0; snzbtn = 1'b0; tick();
        press(2);
        chk("disarm", dut_st, 16'h0000);

        // Editing the alarm onto the current time while armed rings.
        cur_h = 7; cur_m = 0;
        press(2);
        sel = MODE_SEL; hrbtn = 1'b1; tick();
        chk("edit_al", dut_al, 16'h0700);
        sel = 2'b00; hrbtn = 1'b0; tick();
        chk("edit_retrigger", dut_st, 16'h0006);
        press(2);
        press(2);
        chk("edit_disarm", dut_st, 16'h0000);

        // Asynchronous reset mid-snooze with alarm 11:45.
        sel = MODE_SEL;
        for (int i = 0; i < 4; i++) press(0);
        for (int i = 0; i < 45; i++) press(1);
        sel = 2'b00;
        chk("al_1145", dut_al, 16'h1145);
        cur_h = 11; cur_m = 44;
        press(2);
        cur_m = 45; tick();
        press(3);
        repeat (5) tick();
        chk("mid_snooze", dut_st, 16'h0005);
        @(posedge clk1sec);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_al", dut_al, 16'h0600);
        chk("async_rst_st", dut_st, 16'h0000);
        model_reset();
        @(negedge clk1sec);
        rst = 1'b0;
        tick();

        // Random run against the model; time often steered onto the alarm.
        for (int n = 0; n < 4000; n++) begin
            sel    = ($urandom_range(0, 2) == 0) ? MODE_SEL : 2'($urandom_range(0, 3));
            hrbtn  = ($urandom_range(0, 39) == 0);
            minbtn = ($urandom_range(0, 29) == 0);
            armbtn = ($urandom_range(0, 49) == 0);
            snzbtn = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cur_h = m_alh; cur_m = m_alm;
            end else if ($urandom_range(0, 19) == 0) begin
                cur_h = $urandom_range(1, 12); cur_m = $urandom_range(0, 59);
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
